// File: rtl/video_pixel_sink_if.sv
// Pixel-write stream into the sink, its plot-style output port and status flags.
// The master side is the environment (upstream writer and frame-buffer writer).
interface video_pixel_sink_if;
  logic [8:0]  in_x;
  logic [7:0]  in_y;
  logic [4:0]  in_red;
  logic [5:0]  in_green;
  logic [4:0]  in_blue;
  logic        in_pixel_en;
  logic        waitrequest;

  logic [8:0]  out_x;
  logic [7:0]  out_y;
  logic [2:0]  out_colour;
  logic        out_plot;
  logic        out_ready;

  logic [15:0] frame_count;
  logic        drop_flag;

  modport master (
    output in_x, in_y, in_red, in_green, in_blue, in_pixel_en, out_ready,
    input  waitrequest, out_x, out_y, out_colour, out_plot, frame_count, drop_flag
  );

  modport slave (
    input  in_x, in_y, in_red, in_green, in_blue, in_pixel_en, out_ready,
    output waitrequest, out_x, out_y, out_colour, out_plot, frame_count, drop_flag
  );
endinterface

// File: rtl/video_pixel_sink.sv
// Video pixel sink: thresholds RGB565 to 3-bit colour, gates whole frames,
// buffers in a FIFO and drains through a registered valid/ready plot slot.
module video_pixel_sink #(
  parameter int FIFO_AW = 4,
  parameter int THRESH  = 16,
  parameter int SKIP    = 0
) (
  input  logic              clock,
  input  logic              resetn,
  video_pixel_sink_if.slave bus
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = FIFO_AW + 1;
  localparam int SKW   = (SKIP > 1) ? $clog2(SKIP + 1) : 1;

  typedef enum logic [1:0] {
    ST_WAIT_SOF = 2'd0,
    ST_PASS     = 2'd1,
    ST_SKIP     = 2'd2
  } state_e;

  state_e             state_q;
  logic [SKW-1:0]     skip_cnt_q;

  logic               sof;
  logic               eff_pass;
  logic               full;
  logic               empty;
  logic               push;
  logic               lost;
  logic               xfer;
  logic               load;
  logic [2:0]         colour_w;
  logic [19:0]        entry_w;

  logic [19:0]        mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q;
  logic [FIFO_AW-1:0] rd_ptr_q;
  logic [CW-1:0]      count_q;
  logic [CW-1:0]      count_d;

  logic               plot_q;
  logic [8:0]         x_q;
  logic [7:0]         y_q;
  logic [2:0]         colour_q;
  logic [15:0]        frame_count_q;
  logic               drop_q;

  assign sof = bus.in_pixel_en && (bus.in_x == 9'd0) && (bus.in_y == 8'd0);

  // Green is a 6-bit component, so its threshold is doubled to keep the same ratio.
  assign colour_w = {int'(bus.in_red)   >= THRESH,
                     int'(bus.in_green) >= 2 * THRESH,
                     int'(bus.in_blue)  >= THRESH};
  assign entry_w  = {bus.in_x, bus.in_y, colour_w};

  // The SOF pixel belongs to the frame it opens, so the gate is evaluated
  // against the state this pixel moves into, not the registered one.
  // NOTE: combinational blocks use blocking assignments and assign a default
  // first, so every path drives the output and no latch is inferred.
  always_comb begin
    eff_pass = (state_q == ST_PASS);
    if (sof) begin
      unique case (state_q)
        ST_WAIT_SOF: eff_pass = 1'b1;
        ST_PASS:     eff_pass = (SKIP == 0);
        ST_SKIP:     eff_pass = (skip_cnt_q == SKW'(SKIP));
        default:     eff_pass = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_WAIT_SOF;
      skip_cnt_q <= '0;
    end else if (sof) begin
      unique case (state_q)
        ST_WAIT_SOF: begin
          state_q    <= ST_PASS;
          skip_cnt_q <= '0;
        end
        ST_PASS: begin
          if (SKIP != 0) begin
            state_q    <= ST_SKIP;
            skip_cnt_q <= SKW'(1);
          end
        end
        ST_SKIP: begin
          if (skip_cnt_q == SKW'(SKIP)) begin
            state_q    <= ST_PASS;
            skip_cnt_q <= '0;
          end else begin
            skip_cnt_q <= skip_cnt_q + SKW'(1);
          end
        end
        default: begin
          state_q    <= ST_WAIT_SOF;
          skip_cnt_q <= '0;
        end
      endcase
    end
  end

  // Full/empty come from the registered count: a same-cycle pop never admits a push.
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = bus.in_pixel_en && eff_pass && !full;
  assign lost  = bus.in_pixel_en && eff_pass && full;

  assign xfer  = plot_q && bus.out_ready;
  assign load  = (!plot_q || xfer) && !empty;

  always_comb begin
    count_d = count_q;
    case ({push, load})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: the storage array has no reset; emptiness is defined by the
  // pointers and count alone, so stale entries are never observable.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= entry_w;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      end
      if (load) begin
        rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      end
      count_q <= count_d;
    end
  end

  // Output slot: refilled on the same edge that hands its word downstream.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      plot_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
    end else if (load) begin
      plot_q                 <= 1'b1;
      {x_q, y_q, colour_q}   <= mem_q[rd_ptr_q];
    end else if (xfer) begin
      plot_q <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      frame_count_q <= '0;
      drop_q        <= 1'b0;
    end else begin
      if (sof) begin
        frame_count_q <= frame_count_q + 16'd1;
      end
      if (lost) begin
        drop_q <= 1'b1;
      end
    end
  end

  assign bus.waitrequest = full;
  assign bus.out_plot    = plot_q;
  assign bus.out_x       = x_q;
  assign bus.out_y       = y_q;
  assign bus.out_colour  = colour_q;
  assign bus.frame_count = frame_count_q;
  assign bus.drop_flag   = drop_q;

endmodule

// File: tb/tb_video_pixel_sink.sv
// Bench for video_pixel_sink: two instances (SKIP=0 and SKIP=2) share one stimulus
// stream; a frame-index reference model feeds scoreboards popped by output monitors.
`timescale 1ns/1ps
module tb_video_pixel_sink;

  localparam int FIFO_AW = 4;
  localparam int DEPTH   = 1 << FIFO_AW;
  localparam int THRESH  = 16;
  localparam int SKIP1   = 2;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  video_pixel_sink_if bus0 ();
  video_pixel_sink_if bus1 ();

  video_pixel_sink #(.FIFO_AW(FIFO_AW), .THRESH(THRESH), .SKIP(0)) dut0 (
    .clock(clock), .resetn(resetn), .bus(bus0)
  );
  video_pixel_sink #(.FIFO_AW(FIFO_AW), .THRESH(THRESH), .SKIP(SKIP1)) dut1 (
    .clock(clock), .resetn(resetn), .bus(bus1)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: frames are numbered from the first SOF after reset and a
  // frame passes when its index is a multiple of SKIP+1.
  int  skipv [2] = '{0, SKIP1};
  bit  seen  [2];
  int  fidx  [2];
  int  mfifo [2];
  bit  mslot [2];
  bit  mdrop [2];
  int  mframes;
  logic [19:0] expq0 [$];
  logic [19:0] expq1 [$];
  int  xfers0 = 0;
  int  xfers1 = 0;
  logic [2:0] last_col0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] colour_of(int r, int g, int b);
    return {r >= THRESH, g >= 2 * THRESH, b >= THRESH};
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      seen[d]  = 1'b0;
      fidx[d]  = 0;
      mfifo[d] = 0;
      mslot[d] = 1'b0;
      mdrop[d] = 1'b0;
    end
    mframes = 0;
    expq0.delete();
    expq1.delete();
  endtask

  task automatic model_step(int d, bit en, int x, int y, int r, int g, int b, bit rdy);
    bit sof, pass, acc, xfer, load;
    logic [8:0] xv;
    logic [7:0] yv;
    sof = en && (x == 0) && (y == 0);
    if (sof) begin
      fidx[d] = seen[d] ? fidx[d] + 1 : 0;
      seen[d] = 1'b1;
    end
    pass = seen[d] && ((fidx[d] % (skipv[d] + 1)) == 0);
    acc  = en && pass && (mfifo[d] < DEPTH);
    if (en && pass && (mfifo[d] >= DEPTH)) mdrop[d] = 1'b1;
    xfer = mslot[d] && rdy;
    load = (!mslot[d] || xfer) && (mfifo[d] > 0);
    if (load) mslot[d] = 1'b1;
    else if (xfer) mslot[d] = 1'b0;
    mfifo[d] = mfifo[d] - int'(load) + int'(acc);
    if (acc) begin
      xv = 9'(x);
      yv = 8'(y);
      if (d == 0) expq0.push_back({xv, yv, colour_of(r, g, b)});
      else        expq1.push_back({xv, yv, colour_of(r, g, b)});
    end
  endtask

  task automatic drive(bit en, int x, int y, int r, int g, int b, bit rdy);
    bus0.in_pixel_en = en;  bus1.in_pixel_en = en;
    bus0.in_x = 9'(x);      bus1.in_x = 9'(x);
    bus0.in_y = 8'(y);      bus1.in_y = 8'(y);
    bus0.in_red = 5'(r);    bus1.in_red = 5'(r);
    bus0.in_green = 6'(g);  bus1.in_green = 6'(g);
    bus0.in_blue = 5'(b);   bus1.in_blue = 5'(b);
    bus0.out_ready = rdy;   bus1.out_ready = rdy;
  endtask

  task automatic check_state();
    check("wait0",   bus0.waitrequest, mfifo[0] == DEPTH);
    check("wait1",   bus1.waitrequest, mfifo[1] == DEPTH);
    check("plot0",   bus0.out_plot,    mslot[0]);
    check("plot1",   bus1.out_plot,    mslot[1]);
    check("drop0",   bus0.drop_flag,   mdrop[0]);
    check("drop1",   bus1.drop_flag,   mdrop[1]);
    check("frames0", bus0.frame_count, mframes);
    check("frames1", bus1.frame_count, mframes);
  endtask

  // Called #1 after a rising edge; returns #1 after the next one.
  task automatic cycle(bit en, int x, int y, int r, int g, int b, bit rdy);
    check_state();
    drive(en, x, y, r, g, b, rdy);
    model_step(0, en, x, y, r, g, b, rdy);
    model_step(1, en, x, y, r, g, b, rdy);
    if (en && (x == 0) && (y == 0)) mframes = (mframes + 1) % 65536;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(bit rdy);
    cycle(1'b0, 0, 0, 0, 0, 0, rdy);
  endtask

  task automatic reset_now();
    resetn = 1'b0;
    drive(1'b0, 0, 0, 0, 0, 0, 1'b1);
    model_reset();
    #1;
    check("rst_plot0",  bus0.out_plot, 0);
    check("rst_plot1",  bus1.out_plot, 0);
    check("rst_word0",  {bus0.out_x, bus0.out_y, bus0.out_colour}, 0);
    check("rst_word1",  {bus1.out_x, bus1.out_y, bus1.out_colour}, 0);
    check("rst_wait0",  bus0.waitrequest, 0);
    check("rst_wait1",  bus1.waitrequest, 0);
    check("rst_fc0",    bus0.frame_count, 0);
    check("rst_fc1",    bus1.frame_count, 0);
    check("rst_drop0",  bus0.drop_flag, 0);
    check("rst_drop1",  bus1.drop_flag, 0);
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1;
  endtask

  task automatic drain(int budget);
    int n = 0;
    while ((mslot[0] || mslot[1] || mfifo[0] > 0 || mfifo[1] > 0) && n < budget) begin
      idle(1'b1);
      n++;
    end
    check("drain_in_budget", n < budget, 1);
    check("drain_q0", expq0.size(), 0);
    check("drain_q1", expq1.size(), 0);
  endtask

  // Monitors: a transfer happens at the next rising edge when plot and ready are both high.
  always @(negedge clock) begin
    if (resetn && bus0.out_plot && bus0.out_ready) begin
      if (expq0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out0_unexpected actual=%0h required=none",
                 {bus0.out_x, bus0.out_y, bus0.out_colour});
      end else begin
        check("out0", {bus0.out_x, bus0.out_y, bus0.out_colour}, expq0.pop_front());
      end
      xfers0++;
      last_col0 = bus0.out_colour;
    end
  end

  always @(negedge clock) begin
    if (resetn && bus1.out_plot && bus1.out_ready) begin
      if (expq1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out1_unexpected actual=%0h required=none",
                 {bus1.out_x, bus1.out_y, bus1.out_colour});
      end else begin
        check("out1", {bus1.out_x, bus1.out_y, bus1.out_colour}, expq1.pop_front());
      end
      xfers1++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base0, base1;
    #1;
    reset_now();

    // Startup: pixel before SOF is discarded; two-edge latency from the SOF pixel.
    base0 = xfers0;
    cycle(1'b1, 5, 5, 31, 63, 31, 1'b1);
    cycle(1'b1, 0, 0, 31, 63, 31, 1'b1);
    check("lat_k_plot0", bus0.out_plot, 0);
    cycle(1'b1, 1, 0, 31, 63, 31, 1'b1);
    check("lat_k1_plot0", bus0.out_plot, 1);
    check("lat_k1_word0", {bus0.out_x, bus0.out_y, bus0.out_colour}, {9'd0, 8'd0, 3'd7});
    cycle(1'b1, 2, 0, 31, 63, 31, 1'b1);
    drain(20);
    check("start_count0", xfers0 - base0, 3);
    check("start_fc0", bus0.frame_count, 1);

    // Colour thresholds.
    cycle(1'b1, 0, 0, 0, 0, 0, 1'b1);
    cycle(1'b1, 1, 1, 15, 31, 15, 1'b1);
    cycle(1'b1, 2, 1, 16, 32, 16, 1'b1);
    cycle(1'b1, 3, 1, 31, 31, 0, 1'b1);
    drain(20);
    check("colour_last0", last_col0, 3'b100);

    // Overflow: 20 pixels with the output stalled.
    base0 = xfers0;
    for (int i = 0; i < 20; i++) cycle(1'b1, i, 0, 31, 63, 31, 1'b0);
    check("full_wait0", bus0.waitrequest, 1);
    check("full_drop0", bus0.drop_flag, 1);
    idle(1'b1);
    check("wait_fall0", bus0.waitrequest, 0);
    drain(40);
    check("full_count0", xfers0 - base0, 17);

    // Randomised traffic with occasional SOFs and backpressure.
    for (int i = 0; i < 1500; i++) begin
      int x, y;
      if ($urandom_range(0, 19) == 0) begin
        x = 0;
        y = 0;
      end else begin
        x = $urandom_range(0, 319);
        y = $urandom_range(0, 239);
      end
      cycle($urandom_range(0, 3) != 0, x, y, $urandom_range(0, 31),
            $urandom_range(0, 63), $urandom_range(0, 31), $urandom_range(0, 9) < 7);
    end
    drain(200);

    // Frame skipping: 7 frames of 3 pixels.
    reset_now();
    base0 = xfers0;
    base1 = xfers1;
    for (int f = 0; f < 7; f++)
      for (int p = 0; p < 3; p++)
        cycle(1'b1, p, 0, $urandom_range(0, 31), $urandom_range(0, 63),
              $urandom_range(0, 31), 1'b1);
    drain(40);
    check("skip_count1", xfers1 - base1, 9);
    check("skip_count0", xfers0 - base0, 21);
    check("skip_fc1", bus1.frame_count, 7);
    check("skip_drop1", bus1.drop_flag, 0);

    // Hold while stalled, then asynchronous reset mid-burst.
    cycle(1'b1, 0, 0, 31, 0, 31, 1'b0);
    cycle(1'b1, 1, 0, 0, 63, 0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("hold_plot0", bus0.out_plot, 1);
      if (expq0.size() > 0)
        check("hold_word0", {bus0.out_x, bus0.out_y, bus0.out_colour}, expq0[0]);
      idle(1'b0);
    end
    #2;
    resetn = 1'b0;
    #1;
    check("async_plot0", bus0.out_plot, 0);
    check("async_plot1", bus1.out_plot, 0);
    reset_now();
    base0 = xfers0;
    cycle(1'b1, 3, 3, 31, 63, 31, 1'b1);
    repeat (4) idle(1'b1);
    check("post_rst_discard0", xfers0 - base0, 0);

    // frame_count wrap.
    reset_now();
    for (int i = 0; i < 65535; i++)
      cycle(1'b1, 0, 0, $urandom_range(0, 31), $urandom_range(0, 63),
            $urandom_range(0, 31), 1'b1);
    check("wrap_ffff0", bus0.frame_count, 16'hFFFF);
    cycle(1'b1, 0, 0, 31, 63, 31, 1'b1);
    check("wrap_zero0", bus0.frame_count, 0);
    check("wrap_zero1", bus1.frame_count, 0);
    drain(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_pixel_sink.md
Name: video_pixel_sink

Overview:
- Consumer end of the video-input pixel-write stream (x, y, RGB565 colour, pixel_en, waitrequest).
- Thresholds each pixel to 3-bit colour and buffers it in a FIFO.
- Applies frame gating: waits for start-of-frame, then passes one frame in every (SKIP+1).
- Drains to a plot-style valid/ready port feeding the 320x240 3-bit frame-buffer writer; asserts waitrequest upstream when full.

Parameters:
- FIFO_AW, 4, FIFO address width; FIFO depth DEPTH = 2^FIFO_AW entries.
- THRESH, 16, red/blue bit set when the 5-bit component >= THRESH; green bit set when the 6-bit component >= 2*THRESH.
- SKIP, 0, frames discarded after each passed frame (0 = pass every frame).

Ports:
- clock  in  1  system clock (50 MHz domain).
- resetn  in  1  reset, asynchronous, active-low.
- in_x  in  9  pixel column, 0..319.
- in_y  in  8  pixel row, 0..239.
- in_red  in  5  red component.
- in_green  in  6  green component.
- in_blue  in  5  blue component.
- in_pixel_en  in  1  upstream offers a pixel this cycle.
- waitrequest  out  1  high = FIFO full, offered pixel not accepted.
- out_x  out  9  drained pixel column.
- out_y  out  8  drained pixel row.
- out_colour  out  3  {R,G,B} thresholded colour.
- out_plot  out  1  output valid.
- out_ready  in  1  downstream accepts the output word this cycle.
- frame_count  out  16  start-of-frame events seen since reset; wraps at 0xFFFF -> 0.
- drop_flag  out  1  sticky; set when a pixel in a passed frame was offered while full.

Behaviour:
- Reset (async, resetn=0): FIFO empty, output register invalid.
- Reset values: out_plot=0, out_x=0, out_y=0, out_colour=0, waitrequest=0, frame_count=0, drop_flag=0, skip counter=0, state=WAIT_SOF.
- Reset mid-operation discards all buffered pixels.
- SOF event: in_pixel_en=1 with in_x=0 and in_y=0. Evaluated whether or not waitrequest is high. frame_count increments on each SOF.
- State machine (3 states):
  - WAIT_SOF: all pixels discarded. On SOF -> PASS, skip counter=0; the SOF pixel itself is handled as PASS.
  - PASS: at SOF, if SKIP=0 stay PASS; else -> SKIP with skip counter=1 and the SOF pixel discarded.
  - SKIP: at SOF, if skip counter==SKIP -> PASS (skip counter=0, SOF pixel handled as PASS); else skip counter+1, stay SKIP.
- Discarded pixels (WAIT_SOF/SKIP) are never written and never set drop_flag.
- Accept rule: a pixel is written when in_pixel_en=1, effective state PASS, and FIFO not full.
- waitrequest = FIFO full. It is computed from registered occupancy, so a pop in the same cycle does not admit a push.
- Offered while full in PASS: pixel lost, drop_flag set (cleared only by reset), FIFO unchanged.
- FIFO entry is 20 bits: {x[8:0], y[7:0], colour[2:0]}. Colour is computed before the write:
  - R = in_red >= THRESH
  - G = in_green >= 2*THRESH (7-bit compare, no overflow)
  - B = in_blue >= THRESH
- Output stage is a registered valid/ready slot; transfer occurs when out_plot=1 and out_ready=1.
- While out_plot=1 and out_ready=0, out_x, out_y and out_colour are held stable.
- Slot loads from the FIFO head when empty or being transferred and FIFO non-empty. Back-to-back transfers sustain 1 pixel/cycle.
- Latency: pixel accepted at edge k is written at k. If the FIFO and slot were empty, the slot loads at edge k+1, so out_plot=1 after edge k+1.
- Total buffering is DEPTH+1 pixels (FIFO plus slot).
- Simultaneous push and pop on a non-full, non-empty FIFO leaves occupancy unchanged. Pointers wrap modulo DEPTH.
- Occupancy counter is FIFO_AW+1 bits wide and never exceeds DEPTH.
- Pixel order is preserved exactly.

Test Plan:
- Reset, out_ready=1, pixels (5,5),(0,0),(1,0),(2,0) with RGB565 = {31,63,31} -> (5,5) dropped (WAIT_SOF); out_plot outputs (0,0,7),(1,0,7),(2,0,7) in order; first out_plot 2 cycles after SOF offered; frame_count=1.
- Colour boundaries, THRESH=16: {15,31,15}->3'b000; {16,32,16}->3'b111; {31,31,0}->3'b100.
- out_ready=0, 20 consecutive PASS pixels (FIFO_AW=4) -> 17 held (16 FIFO + 1 slot); waitrequest=1 from the 17th accepted write; pixels 18-20 lost; drop_flag=1; release out_ready -> 17 pixels emerge in order at 1/cycle, waitrequest falls 1 cycle after first transfer.
- SKIP=2, 7 frames each starting at (0,0) with 3 pixels -> only frames 1,4,7 reach out_plot (9 pixels); frame_count=7; drop_flag=0.
- out_plot=1 with out_ready=0 for 5 cycles -> out_x/out_y/out_colour unchanged; assert resetn=0 asynchronously mid-burst -> out_plot=0 immediately, FIFO empty, state WAIT_SOF; post-reset pixel (3,3) is discarded.
- Drive 0xFFFF SOF events (by force or a short frame loop) then one more -> frame_count wraps to 0.
